// File: rtl/vga_sync_monitor_if.sv
// Video stream into the sync monitor plus the recovered timing/pixel results.
interface vga_sync_monitor_if;
  logic        pix_en;
  logic        hs_in;
  logic        vs_in;
  logic [5:0]  rgb_in;
  logic        locked;
  logic        active;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [5:0]  rgb_out;
  logic        frame_start;
  logic        err;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;

  modport master (
    output pix_en, hs_in, vs_in, rgb_in,
    input  locked, active, x, y, rgb_out, frame_start, err, line_len, frame_lines
  );

  modport slave (
    input  pix_en, hs_in, vs_in, rgb_in,
    output locked, active, x, y, rgb_out, frame_start, err, line_len, frame_lines
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: recovers x/y from incoming HS/VS/RGB and
// tracks lock against the configured raster.
module vga_sync_monitor #(
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input logic             CLOCK_50,
  input logic             reset,
  vga_sync_monitor_if.slave vid
);

  localparam logic [10:0] H_START   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_STOP    = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_STOP    = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam int          GF_W      = $clog2(LOCK_FRAMES + 1);

  typedef logic [GF_W-1:0] gf_t;
  localparam gf_t GF_LOCK = gf_t'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  logic        hs_p0, hs_p1, vs_p0, vs_p1;
  logic        hs_prev, vs_prev;
  logic        hs_fall, vs_fall;
  logic [10:0] hcnt, hcnt_nxt;
  logic [9:0]  vcnt, vcnt_nxt;
  logic [11:0] hcnt_inc;
  logic [10:0] vcnt_inc;
  logic        h_tmo, v_tmo;
  logic        line_err, frame_err, bad;
  state_t      state, state_nxt;
  gf_t         gf, gf_nxt, gf_inc;
  logic        err_set, fs_set, err_q, fs_q;
  logic        win;

  function automatic logic in_window(input logic [10:0] h, input logic [9:0] v);
    return (h >= H_START) && (h < H_STOP) && (v >= V_START) && (v < V_STOP);
  endfunction

  // Stage p0/p1: two-flop synchroniser; edge history advances only on pix_en
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      hs_p0   <= 1'b0;
      hs_p1   <= 1'b0;
      vs_p0   <= 1'b0;
      vs_p1   <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      hs_p0 <= vid.hs_in;
      hs_p1 <= hs_p0;
      vs_p0 <= vid.vs_in;
      vs_p1 <= vs_p0;
      if (vid.pix_en) begin
        hs_prev <= hs_p1;
        vs_prev <= vs_p1;
      end
    end
  end

  assign hs_fall = vid.pix_en & hs_prev & ~hs_p1;
  assign vs_fall = vid.pix_en & vs_prev & ~vs_p1;

  always_comb begin
    hcnt_inc = {1'b0, hcnt} + 12'd1;
    vcnt_inc = {1'b0, vcnt} + 11'd1;
    hcnt_nxt = hcnt;
    vcnt_nxt = vcnt;
    h_tmo    = 1'b0;
    v_tmo    = 1'b0;
    if (vid.pix_en) begin
      if (hs_fall) begin
        hcnt_nxt = '0;
      end else if (hcnt != 11'h7FF) begin
        hcnt_nxt = hcnt_inc[10:0];
        h_tmo    = (hcnt_inc[10:0] == 11'h7FF);
      end
      // VS reset takes priority over the coincident HS line increment
      if (vs_fall) begin
        vcnt_nxt = '0;
      end else if (hs_fall && (vcnt != 10'h3FF)) begin
        vcnt_nxt = vcnt_inc[9:0];
        v_tmo    = (vcnt_inc[9:0] == 10'h3FF);
      end
    end
    line_err  = hs_fall && (hcnt_inc != H_TOTAL_C);
    frame_err = vs_fall && (vcnt_inc != V_TOTAL_C);
    bad       = line_err | frame_err | h_tmo | v_tmo;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      hcnt            <= '0;
      vcnt            <= '0;
      vid.line_len    <= '0;
      vid.frame_lines <= '0;
    end else begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
      if (hs_fall) vid.line_len    <= hcnt_inc[10:0];
      if (vs_fall) vid.frame_lines <= vcnt_inc[9:0];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state <= SEARCH;
      gf    <= '0;
      err_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      gf    <= gf_nxt;
      err_q <= err_set;
      fs_q  <= fs_set;
    end
  end

  always_comb begin
    state_nxt = state;
    gf_nxt    = gf;
    gf_inc    = gf + gf_t'(1);
    err_set   = 1'b0;
    fs_set    = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_nxt = ALIGN;
          gf_nxt    = '0;
        end
      end
      ALIGN: begin
        if (bad) begin
          state_nxt = SEARCH;
          err_set   = 1'b1;
        end else if (vs_fall) begin
          gf_nxt = gf_inc;
          if (gf_inc == GF_LOCK) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (bad) begin
          state_nxt = SEARCH;
          err_set   = 1'b1;
        end else if (vs_fall) begin
          fs_set = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    vid.locked      = (state == LOCKED);
    vid.err         = err_q;
    vid.frame_start = fs_q;
  end

  // Output stage: uses the post-update counters so x/y/rgb refer to the sampled pixel
  assign win = (state_nxt == LOCKED) && in_window(hcnt_nxt, vcnt_nxt);

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      vid.active  <= 1'b0;
      vid.x       <= '0;
      vid.y       <= '0;
      vid.rgb_out <= '0;
    end else if (vid.pix_en) begin
      vid.active  <= win;
      vid.x       <= win ? 10'(hcnt_nxt - H_START) : 10'd0;
      vid.y       <= win ? (vcnt_nxt - V_START) : 10'd0;
      vid.rgb_out <= win ? vid.rgb_in : 6'd0;
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a reduced 28x14 raster (4/3/16 and 2/3/6).
module tb_vga_sync_monitor;

  localparam int T_HS = 4;
  localparam int T_HT = 28;
  localparam int T_VS = 2;
  localparam int T_VT = 14;

  logic CLOCK_50;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   ftag;
  int   err_cnt;
  int   fs_cnt;
  int   err_base;

  vga_sync_monitor_if vif();

  vga_sync_monitor #(
    .H_SYNC(4), .H_BACK(3), .H_ACTIVE(16), .H_TOTAL(28),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(6), .V_TOTAL(14),
    .LOCK_FRAMES(2)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .vid(vif)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    err_cnt = 0;
    fs_cnt  = 0;
  end

  always @(posedge CLOCK_50) begin
    if (vif.err === 1'b1)         err_cnt <= err_cnt + 1;
    if (vif.frame_start === 1'b1) fs_cnt  <= fs_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] rgb_of(input int l, input int g);
    return 6'((l * 7 + g * 3 + 1) & 63);
  endfunction

  task automatic pix_drive(input logic hs, input logic vs, input logic [5:0] rgb);
    @(negedge CLOCK_50);
    vif.hs_in  = hs;
    vif.vs_in  = vs;
    vif.rgb_in = rgb;
    vif.pix_en = 1'b1;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pix_idle();
    @(negedge CLOCK_50);
    vif.pix_en = 1'b0;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic hook_a(input int l, input int g);
    case (ftag)
      2: if (l == 13 && g == 27) check("unlocked_before_3rd_vs", vif.locked, 0);
      3: begin
        if (l == 0 && g == 0) begin
          check("locked_at_3rd_vs", vif.locked, 1);
          check("no_fs_on_lock_edge", vif.frame_start, 0);
        end
        if (l == 5 && g == 6) check("win_left_off", vif.active, 0);
        if (l == 4 && g == 7) check("win_top_off", vif.active, 0);
        if (l == 5 && g == 7) begin
          check("first_px_active", vif.active, 1);
          check("first_px_x", vif.x, 0);
          check("first_px_y", vif.y, 0);
          check("first_px_rgb", vif.rgb_out, rgb_of(5, 7));
        end
        if (l == 10 && g == 22) begin
          check("last_px_active", vif.active, 1);
          check("last_px_x", vif.x, 15);
          check("last_px_y", vif.y, 5);
          check("last_px_rgb", vif.rgb_out, rgb_of(10, 22));
        end
        if (l == 10 && g == 23) begin
          check("right_edge_off", vif.active, 0);
          check("right_edge_x", vif.x, 0);
        end
      end
      4: if (l == 0 && g == 0) check("frame_start_pulse", vif.frame_start, 1);
      5: begin
        if (l == 3 && g == 26) check("locked_before_short", vif.locked, 1);
        if (l == 4 && g == 0) begin
          check("short_line_err", vif.err, 1);
          check("short_line_len", vif.line_len, 27);
          check("short_line_unlock", vif.locked, 0);
        end
      end
      9: if (l == 12 && g == 27) check("locked_in_short_frame", vif.locked, 1);
      10: if (l == 0 && g == 0) begin
        check("short_frame_err", vif.err, 1);
        check("short_frame_lines", vif.frame_lines, 13);
        check("short_frame_unlock", vif.locked, 0);
      end
      default: ;
    endcase
  endtask

  task automatic hook_b(input int l, input int g);
    case (ftag)
      3: if (l == 10 && g == 22) begin
        check("hold_active", vif.active, 1);
        check("hold_x", vif.x, 15);
      end
      4: if (l == 0 && g == 0) check("frame_start_width", vif.frame_start, 0);
      5: if (l == 4 && g == 0) check("err_width", vif.err, 0);
      default: ;
    endcase
  endtask

  // Sync levels are driven one pixel early so the DUT's hcnt/vcnt equal (g, l).
  task automatic send_line(input int l, input int len, input int vt, input int g0, input int g1);
    int gn, ln;
    for (int g = g0; g <= g1; g++) begin
      if (g == len - 1) begin
        gn = 0;
        ln = (l + 1) % vt;
      end else begin
        gn = g + 1;
        ln = l;
      end
      pix_drive(gn >= T_HS, ln >= T_VS, rgb_of(l, g));
      hook_a(l, g);
      pix_idle();
      hook_b(l, g);
    end
  endtask

  task automatic send_frame(input int vt, input int short_l);
    int len;
    for (int l = 0; l < vt; l++) begin
      len = (l == short_l) ? T_HT - 1 : T_HT;
      send_line(l, len, vt, 0, len - 1);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_locked"}, vif.locked, 0);
    check({pfx, "_active"}, vif.active, 0);
    check({pfx, "_x"}, vif.x, 0);
    check({pfx, "_y"}, vif.y, 0);
    check({pfx, "_rgb"}, vif.rgb_out, 0);
    check({pfx, "_err"}, vif.err, 0);
    check({pfx, "_fs"}, vif.frame_start, 0);
    check({pfx, "_line_len"}, vif.line_len, 0);
    check({pfx, "_frame_lines"}, vif.frame_lines, 0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    ftag       = 0;
    reset      = 1'b0;
    vif.pix_en = 1'b0;
    vif.hs_in  = 1'b1;
    vif.vs_in  = 1'b1;
    vif.rgb_in = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_outputs("rst");
    @(negedge CLOCK_50);
    reset = 1'b1;

    for (int l = 7; l < T_VT; l++) send_line(l, T_HT, T_VT, 0, T_HT - 1);
    ftag = 1; send_frame(T_VT, -1);
    check("locked_after_1st_vs", vif.locked, 0);
    ftag = 2; send_frame(T_VT, -1);
    ftag = 3; send_frame(T_VT, -1);
    ftag = 4; send_frame(T_VT, -1);
    check("clean_no_err", err_cnt, 0);
    check("clean_fs_count", fs_cnt, 1);
    check("clean_line_len", vif.line_len, 28);
    check("clean_frame_lines", vif.frame_lines, 14);

    ftag = 5; send_frame(T_VT, 3);
    check("short_line_err_once", err_cnt, 1);
    ftag = 6; send_frame(T_VT, -1);
    ftag = 7; send_frame(T_VT, -1);
    check("relock_pending", vif.locked, 0);
    ftag = 8; send_frame(T_VT, -1);
    check("relocked", vif.locked, 1);

    ftag = 9;  send_frame(T_VT - 1, -1);
    ftag = 10; send_frame(T_VT, -1);
    check("short_frame_err_total", err_cnt, 2);
    ftag = 11; send_frame(T_VT, -1);
    ftag = 12; send_frame(T_VT, -1);
    ftag = 13; send_frame(T_VT, -1);
    check("locked_before_timeout", vif.locked, 1);

    ftag = 0;
    err_base = err_cnt;
    for (int i = 0; i < 2100; i++) begin
      pix_drive(1'b1, 1'b1, 6'd0);
      pix_idle();
    end
    check("timeout_err_once", err_cnt - err_base, 1);
    check("timeout_unlock", vif.locked, 0);
    check("timeout_line_len", vif.line_len, 28);

    send_line(13, T_HT, T_VT, 0, T_HT - 1);
    ftag = 14; send_frame(T_VT, -1);
    ftag = 15; send_frame(T_VT, -1);
    ftag = 16; send_frame(T_VT, -1);
    check("locked_before_reset", vif.locked, 1);

    ftag = 17;
    for (int l = 0; l < 6; l++) send_line(l, T_HT, T_VT, 0, T_HT - 1);
    send_line(6, T_HT, T_VT, 0, 10);
    check("pre_reset_active", vif.active, 1);
    check("pre_reset_x", vif.x, 3);
    check("pre_reset_y", vif.y, 1);
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(posedge CLOCK_50);
    #1;
    check_reset_outputs("midrst");
    @(negedge CLOCK_50);
    reset = 1'b1;
    send_line(6, T_HT, T_VT, 11, T_HT - 1);
    for (int l = 7; l < T_VT; l++) send_line(l, T_HT, T_VT, 0, T_HT - 1);
    check("search_after_reset", vif.locked, 0);
    ftag = 18; send_frame(T_VT, -1);
    ftag = 19; send_frame(T_VT, -1);
    check("post_reset_pending", vif.locked, 0);
    ftag = 20; send_frame(T_VT, -1);
    check("post_reset_relock", vif.locked, 1);
    check("total_err_count", err_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
